// File: rtl/fetch_seq_ctrl_if.sv
// Purpose: bundles the control, BRAM read and output stream signals of the
//          fetch sequencer into one interface.
// Modports:
//   master - the sequencer: drives busy/fetch_done, the BRAM read port
//            (bram_en/bram_addr) and the output stream (m_valid/m_data/m_last);
//            receives the start controls, bram_dout and m_ready.
//   slave  - the environment: the mirror image of master.
interface fetch_seq_ctrl_if #(
  parameter int DATA_WIDTH    = 256,
  parameter int BUF_SEL_WIDTH = 2,
  parameter int REGION_WORDS  = 512,
  parameter int ADDR_WIDTH    = 11,
  parameter int LEN_WIDTH     = 10
);
  localparam int OFF_WIDTH = $clog2(REGION_WORDS);

  // Fetch control
  logic                     start_fetch;
  logic [BUF_SEL_WIDTH-1:0] buf_sel;
  logic [OFF_WIDTH-1:0]     start_offset;
  logic [LEN_WIDTH-1:0]     fetch_len;
  logic                     continue_fetch;
  logic                     clear_ptrs;
  logic                     busy;
  logic                     fetch_done;

  // BRAM read port
  logic                     bram_en;
  logic [ADDR_WIDTH-1:0]    bram_addr;
  logic [DATA_WIDTH-1:0]    bram_dout;

  // Output stream
  logic                     m_valid;
  logic [DATA_WIDTH-1:0]    m_data;
  logic                     m_last;
  logic                     m_ready;

  modport master (
    input  start_fetch, buf_sel, start_offset, fetch_len, continue_fetch,
           clear_ptrs, bram_dout, m_ready,
    output busy, fetch_done, bram_en, bram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start_fetch, buf_sel, start_offset, fetch_len, continue_fetch,
           clear_ptrs, bram_dout, m_ready,
    input  busy, fetch_done, bram_en, bram_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Purpose: read-side fetch sequencer for a wide BRAM split into NUM_BUFFERS
//          equal regions. Issues region-relative read addresses (wrapping
//          inside the selected region), absorbs the BRAM read latency with a
//          credit-controlled skid FIFO and delivers the words on a valid/ready
//          stream. Each region keeps a resume pointer for continued fetches.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - fetch_seq_ctrl_if.master: start_fetch/buf_sel/start_offset/
//          fetch_len/continue_fetch/clear_ptrs in, busy/fetch_done out,
//          bram_en/bram_addr out, bram_dout in, m_valid/m_data/m_last out,
//          m_ready in.
module fetch_seq_ctrl #(
  parameter int DATA_WIDTH    = 256,
  parameter int NUM_BUFFERS   = 4,
  parameter int BUF_SEL_WIDTH = 2,
  parameter int REGION_WORDS  = 512,
  parameter int ADDR_WIDTH    = 11,
  parameter int LEN_WIDTH     = 10,
  parameter int BRAM_LATENCY  = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  fetch_seq_ctrl_if.master bus
);

  localparam int OFF_W  = $clog2(REGION_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [BUF_SEL_WIDTH-1:0] r_buf;
  logic [OFF_W-1:0]         r_ptr;
  logic [LEN_WIDTH-1:0]     r_remain;
  logic                     r_len_nz;
  logic [OFF_W-1:0]         r_saved [NUM_BUFFERS];

  // Read pipeline: one valid/last pair per cycle of BRAM latency
  logic [BRAM_LATENCY-1:0]  r_vld_p;
  logic [BRAM_LATENCY-1:0]  r_last_p;
  logic [CNT_W-1:0]         r_inflight;

  // Skid FIFO
  logic [DATA_WIDTH-1:0]    r_mem_data [FIFO_DEPTH];
  logic                     r_mem_last [FIFO_DEPTH];
  logic [FPTR_W-1:0]        r_wr;
  logic [FPTR_W-1:0]        r_rd;
  logic [CNT_W-1:0]         r_fcnt;

  logic                     w_busy;
  logic                     w_done;
  logic                     w_bram_en;
  logic                     w_credit_ok;
  logic [CNT_W:0]           w_credit_sum;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_idle_start;
  logic                     w_clear;
  logic [OFF_W-1:0]         w_start_ptr;

  function automatic logic [FPTR_W-1:0] fptr_inc(input logic [FPTR_W-1:0] p);
    return (p == FPTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FPTR_W'(1);
  endfunction

  // Words already committed (in flight or buffered) bound new issues so the
  // FIFO can always absorb every returning read.
  assign w_credit_sum = {1'b0, r_fcnt} + {1'b0, r_inflight};
  assign w_credit_ok  = (w_credit_sum < (CNT_W + 1)'(FIFO_DEPTH));

  assign w_push       = r_vld_p[BRAM_LATENCY-1];
  assign w_pop        = (r_fcnt != '0) && bus.m_ready;
  assign w_idle_start = (r_state == S_IDLE) && bus.start_fetch;

  // Pointer clear is accepted whenever the sequencer is not busy.
  assign w_clear      = bus.clear_ptrs &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));

  // A clear in the same cycle as a continued start resumes from zero.
  assign w_start_ptr  = !bus.continue_fetch ? bus.start_offset :
                        (w_clear ? '0 : r_saved[bus.buf_sel]);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_bram_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Zero-length fetches pass through DRAIN so completion still takes
        // two cycles and the stream machinery is never touched.
        if (bus.start_fetch)
          w_state_nxt = (bus.fetch_len == '0) ? S_DRAIN : S_ISSUE;
      end
      S_ISSUE: begin
        w_busy    = 1'b1;
        w_bram_en = w_credit_ok;
        if (w_credit_ok && (r_remain == LEN_WIDTH'(1)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        // Finish in the cycle the final word is accepted, so fetch_done
        // follows the last handshake by exactly one cycle.
        if ((r_inflight == '0) &&
            ((r_fcnt == '0) || ((r_fcnt == CNT_W'(1)) && w_pop)))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- Stage p0: issue / control registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_ptr      <= '0;
      r_remain   <= '0;
      r_len_nz   <= 1'b0;
      r_vld_p    <= '0;
      r_inflight <= '0;
      r_fcnt     <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      for (int b = 0; b < NUM_BUFFERS; b++) r_saved[b] <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_idle_start) begin
        r_buf    <= bus.buf_sel;
        r_ptr    <= w_start_ptr;
        r_remain <= bus.fetch_len;
        r_len_nz <= (bus.fetch_len != '0);
      end else if (w_bram_en) begin
        // Pointer width equals the region size, so it wraps in-region.
        r_ptr    <= r_ptr + OFF_W'(1);
        r_remain <= r_remain - LEN_WIDTH'(1);
      end

      r_vld_p[0] <= w_bram_en;
      for (int i = 1; i < BRAM_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];

      r_inflight <= r_inflight + CNT_W'(w_bram_en) - CNT_W'(w_push);
      r_fcnt     <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) r_wr <= fptr_inc(r_wr);
      if (w_pop)  r_rd <= fptr_inc(r_rd);

      if (w_clear) begin
        for (int b = 0; b < NUM_BUFFERS; b++) r_saved[b] <= '0;
      end else if ((r_state == S_DONE) && r_len_nz) begin
        r_saved[r_buf] <= r_ptr;
      end
    end
  end

  // ---- Stage p1..pN: read return path into the skid FIFO ----
  always_ff @(posedge clk) begin
    r_last_p[0] <= (r_remain == LEN_WIDTH'(1));
    for (int i = 1; i < BRAM_LATENCY; i++) r_last_p[i] <= r_last_p[i-1];
    if (w_push) begin
      r_mem_data[r_wr] <= bus.bram_dout;
      r_mem_last[r_wr] <= r_last_p[BRAM_LATENCY-1];
    end
  end

  // ---- Output stage ----
  assign bus.busy       = w_busy;
  assign bus.fetch_done = w_done;
  assign bus.bram_en    = w_bram_en;
  assign bus.bram_addr  = ADDR_WIDTH'({r_buf, r_ptr});
  assign bus.m_valid    = (r_fcnt != '0);
  assign bus.m_data     = r_mem_data[r_rd];
  assign bus.m_last     = (r_fcnt != '0) && r_mem_last[r_rd];

endmodule
